transpose_buffer_ctrl: RTL and testbench
========================================

// Module: transpose_buffer_ctrl
// PURPOSE
//  Sequencer for transpose_buffer_32x32 between the row (1st) and column (2nd) 1-D DCT-II passes.
//  Drives enable/direction so rows shift in while the previous block's columns shift out.
//  Direction alternates per block, giving full-throughput streaming.
//  Adds valid/ready handshakes on both sides, plus a zero-fill flush for the final block.
// PARAMETERS
//  N    32  vectors per block (buffer edge); equals the transpose_buffer_32x32 size
//  CW   5   width of the in-block vector counter, $clog2(N)
//  BCW  16  width of the completed-block counter
// PORTS
//  clock        in   1    rising-edge clock
//  reset        in   1    synchronous, active-high
//  in_valid     in   1    1st-pass row vector available on the buffer in_0..in_31
//  in_ready     out  1    controller accepts the row this cycle
//  flush        in   1    no more input: drain the resident block using zero fill
//  out_valid    out  1    buffer out_0..out_31 holds a valid transposed vector
//  out_ready    in   1    2nd pass consumes the vector this cycle
//  out_first    out  1    out_valid and vector 0 of a block
//  out_last     out  1    out_valid and vector N-1 of a block
//  tb_enable    out  1    to buffer enable: shift one vector this cycle
//  tb_direction out  1    to buffer direction: 0 = row-wise fill, 1 = column-wise
//  zero_fill    out  1    datapath mux select: drive buffer inputs with 0
//  blocks_done  out  BCW  count of fully emitted blocks; wraps modulo 2^BCW
// BEHAVIOUR
//  Reset values: state=FILL, cnt=0, tb_direction=0, blocks_done=0, flush_pend=0.
//   All handshake outputs then equal their FILL/cnt=0 values: in_ready=1, others 0.
//  Handshake outputs and tb_enable are combinational from state/cnt/inputs; zero-cycle latency.
//  A shift is tb_enable=1. Input accept = in_valid&in_ready. Output consume = out_valid&out_ready.
//  FILL (buffer empty or partial, first block):
//   - in_ready=1, out_valid=0, shift=in_valid.
//  STREAM (one full block resident):
//   - out_valid=1, in_ready=out_ready, shift=in_valid&out_ready.
//   - out_valid with in_valid=0 never shifts and holds the output vector.
//  FLUSH:
//   - in_ready=0, zero_fill=1, out_valid=1, shift=out_ready.
//  Every shift increments cnt. At cnt=N-1 a shift wraps cnt to 0 and toggles tb_direction.
//  Wrap transitions:
//   - FILL goes to STREAM.
//   - STREAM stays in STREAM, or goes to FLUSH if flush_pend, then blocks_done+1.
//   - FLUSH goes to FILL, then blocks_done+1.
//  Flush handling:
//   - flush=1 in STREAM sets flush_pend; it is cleared on entry to FLUSH.
//   - In STREAM with cnt=0 and no shift, flush_pend or flush moves directly to FLUSH.
//   - flush in FILL with cnt=0 is ignored (nothing resident).
//   - flush in FILL with cnt>0 is held pending; the block completes on real input only.
//  Simultaneous flush and in_valid in STREAM: the input row is accepted and the flush is deferred.
//  out_first = out_valid&(cnt==0); out_last = out_valid&(cnt==N-1).
//  Reset mid-block: controller returns to FILL and partial data is discarded.
//   The buffer is reset on the same reset.
//  Direction must only ever change on a block boundary (cnt wrap).
// STRUCTURE
//  dct2_2d_pkg:
//   - state enum {FILL, STREAM, FLUSH} (2-bit).
//   - localparams N=32 and CW.
//   - DIR_ROW=0 and DIR_COL=1.
//  No sub-module. This block holds the FSM, the cnt and blocks_done counters, and flush_pend.
//  Instantiated beside transpose_buffer_32x32 in the dct2_2d top.
// TESTING
//  1. Reset held 2 cycles: in_ready=1, out_valid=0, tb_direction=0, blocks_done=0.
//  2. 32 in_valid cycles: tb_enable=1 each cycle. After the 32nd: STREAM, tb_direction=1, out_valid=1.
//  3. Streaming with in_valid=out_ready=1 for 64 cycles:
//     - out_first at cycles 0 and 32; out_last at 31 and 63.
//     - blocks_done=2; tb_direction back to 1.
//  4. out_ready=0 for 5 cycles mid-block: tb_enable=0, in_ready=0, outputs held; cnt unchanged.
//  5. flush at cnt=10 in STREAM:
//     - rows continue to cnt=31, then FLUSH with zero_fill=1 for 32 shifts.
//     - Ends in FILL; blocks_done incremented twice.
//  6. reset asserted at cnt=17 in FLUSH: next cycle FILL, cnt=0, tb_direction=0, zero_fill=0.

Source files
------------

// File: rtl/dct2_2d_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dct2_2d_pkg
//  Purpose  : Shared types and constants for the 2-D DCT-II pipeline: the
//             transpose-buffer sequencer state set, buffer edge size and
//             shift-direction encodings.
//  Revision : 1.0  initial release
// ============================================================================
package dct2_2d_pkg;

  // Vectors per block (transpose buffer edge) and in-block counter width
  localparam int N  = 32;
  localparam int CW = $clog2(N);

  // Buffer direction encodings
  localparam logic DIR_ROW = 1'b0;
  localparam logic DIR_COL = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage : dct2_2d_pkg
`default_nettype wire

// File: rtl/transpose_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : transpose_buffer_ctrl
//  Purpose  : Sequencer for the 32x32 transpose buffer sitting between the
//             row and column 1-D DCT passes. Rows shift in while the previous
//             block's columns shift out; direction flips every block so the
//             buffer streams at full rate. Valid/ready on both sides and a
//             zero-fill drain for the final block.
//  Revision : 1.0  initial release
// ============================================================================
module transpose_buffer_ctrl
  import dct2_2d_pkg::*;
#(
  parameter int N   = dct2_2d_pkg::N,
  parameter int CW  = dct2_2d_pkg::CW,
  parameter int BCW = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_first,
  output logic           out_last,
  output logic           tb_enable,
  output logic           tb_direction,
  output logic           zero_fill,
  output logic [BCW-1:0] blocks_done
);

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic           r_dir;
  logic [BCW-1:0] r_blocks;
  logic           r_flush_pend;

  logic           w_wrap;       // shift on the last vector of a block
  logic           w_pend_eff;   // flush request visible this cycle
  logic           w_pend_set;
  logic           w_blk_inc;

  // Handshakes, buffer enable and next state from current state and inputs
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    tb_enable   = 1'b0;
    zero_fill   = 1'b0;
    w_pend_eff  = r_flush_pend;
    w_state_nxt = r_state;

    case (r_state)
      FILL: begin
        in_ready  = 1'b1;
        tb_enable = in_valid;
      end
      STREAM: begin
        out_valid  = 1'b1;
        in_ready   = out_ready;
        tb_enable  = in_valid & out_ready;
        w_pend_eff = r_flush_pend | flush;
      end
      FLUSH: begin
        out_valid = 1'b1;
        zero_fill = 1'b1;
        tb_enable = out_ready;
      end
      default: ;
    endcase

    w_wrap = tb_enable && (r_cnt == C_LAST);

    case (r_state)
      FILL: begin
        if (w_wrap) w_state_nxt = STREAM;
      end
      STREAM: begin
        // A fully resident block with nothing of the next one in yet can
        // start draining immediately; otherwise wait for the block edge.
        if (w_wrap && w_pend_eff)
          w_state_nxt = FLUSH;
        else if (!tb_enable && (r_cnt == '0) && w_pend_eff)
          w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (w_wrap) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase

    // A wrap outside FILL means a whole block has left the buffer
    w_blk_inc  = w_wrap && (r_state != FILL);
    // In FILL with nothing shifted in there is nothing to drain
    w_pend_set = flush && ((r_state == STREAM) ||
                           ((r_state == FILL) && (r_cnt != '0)));
  end

  // State, vector counter, direction, block counter and pending flush
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= FILL;
      r_cnt        <= '0;
      r_dir        <= DIR_ROW;
      r_blocks     <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (tb_enable) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
      if (w_wrap) begin
        r_dir <= ~r_dir;
      end
      if (w_blk_inc) begin
        r_blocks <= r_blocks + BCW'(1);
      end
      if ((w_state_nxt == FLUSH) && (r_state != FLUSH))
        r_flush_pend <= 1'b0;
      else if (w_pend_set)
        r_flush_pend <= 1'b1;
    end
  end

  assign out_first    = out_valid && (r_cnt == '0);
  assign out_last     = out_valid && (r_cnt == C_LAST);
  assign tb_direction = r_dir;
  assign blocks_done  = r_blocks;

endmodule : transpose_buffer_ctrl
`default_nettype wire

// File: tb/tb_transpose_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_transpose_buffer_ctrl
//  Purpose  : Self-checking bench for transpose_buffer_ctrl. A block-level
//             model (resident block / filling / draining with zeros) predicts
//             every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_transpose_buffer_ctrl;

  localparam int NV = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_first;
  logic        out_last;
  logic        tb_enable;
  logic        tb_direction;
  logic        zero_fill;
  logic [15:0] blocks_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  transpose_buffer_ctrl #(.N(32), .CW(5), .BCW(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_first    (out_first),
    .out_last     (out_last),
    .tb_enable    (tb_enable),
    .tb_direction (tb_direction),
    .zero_fill    (zero_fill),
    .blocks_done  (blocks_done)
  );

  // Block-level model: does the buffer hold a complete earlier block, is that
  // block being drained with zeros, position within the current block, how
  // many block boundaries have passed, how many blocks have fully left.
  bit m_have;
  bit m_zeros;
  bit m_pend;
  int m_pos;
  int m_wraps;
  int m_done;

  logic [6:0]  e_vec;   // {in_ready,out_valid,out_first,out_last,tb_enable,tb_direction,zero_fill}
  logic [15:0] e_done;
  logic        e_en;

  task automatic model_reset();
    m_have = 0; m_zeros = 0; m_pend = 0;
    m_pos = 0; m_wraps = 0; m_done = 0;
  endtask

  task automatic model_expect(input logic iv, input logic ordy);
    logic ir, ov, en, zf, of, ol;
    if (!m_have) begin
      ir = 1'b1; ov = 1'b0; en = iv; zf = 1'b0;
    end else if (m_zeros) begin
      ir = 1'b0; ov = 1'b1; en = ordy; zf = 1'b1;
    end else begin
      ir = ordy; ov = 1'b1; en = iv & ordy; zf = 1'b0;
    end
    of = ov && (m_pos == 0);
    ol = ov && (m_pos == NV - 1);
    e_en   = en;
    e_vec  = {ir, ov, of, ol, en, ((m_wraps % 2) == 1), zf};
    e_done = 16'(m_done % 65536);
  endtask

  task automatic model_advance(input logic fl);
    bit streaming, filling, pend_n;
    int pos0;
    streaming = m_have && !m_zeros;
    filling   = !m_have;
    pos0      = m_pos;
    pend_n    = m_pend;
    if (fl && (streaming || (filling && pos0 > 0))) pend_n = 1;
    if (e_en) begin
      m_pos++;
      if (m_pos == NV) begin
        m_pos = 0;
        m_wraps++;
        if (m_have) m_done++;
        if (filling) m_have = 1;
        else if (m_zeros) begin m_have = 0; m_zeros = 0; end
        else if (pend_n) begin m_zeros = 1; pend_n = 0; end
      end
    end else if (streaming && pos0 == 0 && pend_n) begin
      m_zeros = 1;
      pend_n  = 0;
    end
    m_pend = pend_n;
  endtask

  function automatic logic [6:0] obs();
    return {in_ready, out_valid, out_first, out_last, tb_enable, tb_direction, zero_fill};
  endfunction

  // Apply one cycle of inputs at the falling edge and compute expectations
  task automatic drive(input logic iv, input logic ordy, input logic fl);
    @(negedge clock);
    reset = 1'b0; in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    model_expect(iv, ordy);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    model_reset();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || tb_direction !== 1'b0)
      $display("FAIL reset_ctrl got ir=%b ov=%b dir=%b want ir=1 ov=0 dir=0", in_ready, out_valid, tb_direction);
    else n_pass++;
    n_checks++;
    if (blocks_done !== 16'd0) $display("FAIL reset_blocks got=%0d want=0", blocks_done);
    else n_pass++;
    n_checks++;
    if (obs() !== e_vec) $display("FAIL reset_vec got=%b want=%b", obs(), e_vec);
    else n_pass++;
    model_advance(1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (obs() !== e_vec || tb_enable !== 1'b1)
        $display("FAIL fill_vec i=%0d got=%b want=%b", i, obs(), e_vec);
      else n_pass++;
      model_advance(1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || tb_direction !== 1'b1 || out_first !== 1'b1)
      $display("FAIL fill_done got ov=%b dir=%b first=%b want 1 1 1", out_valid, tb_direction, out_first);
    else n_pass++;
    model_advance(1'b0);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2 * NV; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e_vec || out_first !== ((i % NV) == 0) || out_last !== ((i % NV) == NV - 1))
        $display("FAIL stream_vec i=%0d got=%b want=%b", i, obs(), e_vec);
      else n_pass++;
      n_checks++;
      if (blocks_done !== e_done) $display("FAIL stream_blocks i=%0d got=%0d want=%0d", i, blocks_done, e_done);
      else n_pass++;
      model_advance(1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (blocks_done !== 16'd2 || tb_direction !== 1'b1)
      $display("FAIL stream_end got blocks=%0d dir=%b want blocks=2 dir=1", blocks_done, tb_direction);
    else n_pass++;
    model_advance(1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e_vec) $display("FAIL stall_pre i=%0d got=%b want=%b", i, obs(), e_vec);
      else n_pass++;
      model_advance(1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (tb_enable !== 1'b0 || in_ready !== 1'b0 || obs() !== e_vec)
        $display("FAIL stall_hold i=%0d got=%b want=%b", i, obs(), e_vec);
      else n_pass++;
      model_advance(1'b0);
    end
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e_vec) $display("FAIL stall_resume got=%b want=%b", obs(), e_vec);
    else n_pass++;
    model_advance(1'b0);
  endtask

  task automatic test_flush();
    int d0, guard, n_zf;
    guard = 0;
    while (m_pos != 10 && guard < 64) begin
      drive(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e_vec) $display("FAIL flush_seek got=%b want=%b", obs(), e_vec);
      else n_pass++;
      model_advance(1'b0);
      guard++;
    end
    d0 = m_done;
    drive(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs() !== e_vec || in_ready !== 1'b1 || tb_enable !== 1'b1)
      $display("FAIL flush_accept got=%b want=%b", obs(), e_vec);
    else n_pass++;
    model_advance(1'b1);
    guard = 0; n_zf = 0;
    while (!(m_have == 0 && m_pos == 0) && guard < 128) begin
      drive(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e_vec) $display("FAIL flush_run g=%0d got=%b want=%b", guard, obs(), e_vec);
      else n_pass++;
      if (zero_fill === 1'b1 && tb_enable === 1'b1) n_zf++;
      model_advance(1'b0);
      guard++;
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_zf != NV) $display("FAIL flush_zero_shifts got=%0d want=%0d", n_zf, NV);
    else n_pass++;
    n_checks++;
    if (blocks_done !== 16'(d0 + 2) || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_end got blocks=%0d ov=%b want blocks=%0d ov=0", blocks_done, out_valid, d0 + 2);
    else n_pass++;
    model_advance(1'b0);
  endtask

  task automatic test_reset_in_flush();
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      model_advance(1'b0);
    end
    drive(1'b0, 1'b1, 1'b1);
    model_advance(1'b1);
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e_vec || zero_fill !== 1'b1)
        $display("FAIL rstflush_drain i=%0d got=%b want=%b", i, obs(), e_vec);
      else n_pass++;
      model_advance(1'b0);
    end
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(posedge clock);
    model_reset();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || tb_direction !== 1'b0 || zero_fill !== 1'b0)
      $display("FAIL rstflush_state got ir=%b ov=%b dir=%b zf=%b want 1 0 0 0", in_ready, out_valid, tb_direction, zero_fill);
    else n_pass++;
    model_advance(1'b0);
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e_vec) $display("FAIL rstflush_refill i=%0d got=%b want=%b", i, obs(), e_vec);
      else n_pass++;
      model_advance(1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (tb_direction !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL rstflush_cnt got dir=%b ov=%b want dir=1 ov=1", tb_direction, out_valid);
    else n_pass++;
    model_advance(1'b0);
  endtask

  task automatic test_random();
    logic iv, ordy, fl;
    for (int i = 0; i < 3000; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clock);
        reset = 1'b1; in_valid = iv; out_ready = ordy; flush = fl;
        @(posedge clock);
        model_reset();
      end else begin
        drive(iv, ordy, fl);
        n_checks++;
        if (obs() !== e_vec) $display("FAIL random_vec i=%0d got=%b want=%b", i, obs(), e_vec);
        else n_pass++;
        n_checks++;
        if (blocks_done !== e_done) $display("FAIL random_blocks i=%0d got=%0d want=%0d", i, blocks_done, e_done);
        else n_pass++;
        model_advance(fl);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_stream();
    test_stall();
    test_flush();
    test_reset_in_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_transpose_buffer_ctrl
`default_nettype wire
